// File: rtl/array_pair_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : array_pair_unpacker
// Description : Takes one two-element signed array per a_in handshake and
//               emits it on a scalar stream as element 0, element 1 and
//               optionally their saturated sum. Counts completed arrays.
// Revision    : 1.0 - initial release
// ============================================================================
module array_pair_unpacker #(
  parameter int EMIT_SUM = 1,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0][31:0]    a_in,
  input  logic                a_in_sync,
  output logic                a_in_notify,
  output logic signed [31:0]  c_out,
  input  logic                c_out_sync,
  output logic                c_out_notify,
  output logic [CNT_W-1:0]    pair_count
);

  typedef enum logic [1:0] {
    READ = 2'd0,
    WR0  = 2'd1,
    WR1  = 2'd2,
    WRS  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [1:0][31:0]     pair_q, pair_d;
  logic [31:0]          c_out_q, c_out_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 a_in_notify_q;
  logic                 c_out_notify_q;

  logic [32:0]          sum_w;
  logic [31:0]          sat_w;

  // 33-bit sign-extended sum so overflow shows up in the top two bits
  assign sum_w = {pair_q[0][31], pair_q[0]} + {pair_q[1][31], pair_q[1]};

  // Clamp the sum to the signed 32-bit range
  always_comb begin
    sat_w = sum_w[31:0];
    if (sum_w[32:31] == 2'b01) begin
      sat_w = 32'h7FFF_FFFF;
    end else if (sum_w[32:31] == 2'b10) begin
      sat_w = 32'h8000_0000;
    end
  end

  // Next-state logic; notify flags are 1 exactly in the states that accept
  // a transfer, so a sync in the right state is itself the transfer
  always_comb begin
    state_d = state_q;
    pair_d  = pair_q;
    c_out_d = c_out_q;
    cnt_d   = cnt_q;
    case (state_q)
      READ: begin
        if (a_in_sync) begin
          pair_d  = a_in;
          c_out_d = a_in[0];
          state_d = WR0;
        end
      end
      WR0: begin
        if (c_out_sync) begin
          c_out_d = pair_q[1];
          state_d = WR1;
        end
      end
      WR1: begin
        if (c_out_sync) begin
          if (EMIT_SUM != 0) begin
            c_out_d = sat_w;
            state_d = WRS;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = READ;
          end
        end
      end
      WRS: begin
        if (c_out_sync) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = READ;
        end
      end
      default: state_d = READ;
    endcase
  end

  // State, data and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= READ;
      pair_q         <= '0;
      c_out_q        <= '0;
      cnt_q          <= '0;
      a_in_notify_q  <= 1'b1;
      c_out_notify_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pair_q         <= pair_d;
      c_out_q        <= c_out_d;
      cnt_q          <= cnt_d;
      a_in_notify_q  <= (state_d == READ);
      c_out_notify_q <= (state_d != READ);
    end
  end

  assign a_in_notify  = a_in_notify_q;
  assign c_out_notify = c_out_notify_q;
  assign c_out        = c_out_q;
  assign pair_count   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_array_pair_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : tb_array_pair_unpacker
// Description : Scoreboard bench for array_pair_unpacker in two
//               configurations (with sum / 16-bit count, without sum /
//               2-bit count), random data and random back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_array_pair_unpacker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit done [2];

  typedef struct {
    logic [31:0] w;
    bit          last;
  } exp_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  // Reference sum: exact integer add, then clamp to the signed 32-bit range
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
    if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
    return s[31:0];
  endfunction

  // Random operand biased towards the saturation boundaries and zero
  function automatic logic [31:0] rv();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'h7FFF_FFFF - 32'($urandom_range(0, 15));
      2:       return 32'h8000_0000 + 32'($urandom_range(0, 15));
      default: return 32'($urandom_range(0, 20)) - 32'd10;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int ES = (g == 0) ? 1 : 0;
    localparam int CW = (g == 0) ? 16 : 2;

    logic             rst = 1'b1;
    logic [1:0][31:0] a_in = '0;
    logic             a_in_sync = 1'b0;
    logic             c_out_sync = 1'b0;
    logic             a_in_notify;
    logic             c_out_notify;
    logic [31:0]      c_out;
    logic [CW-1:0]    pair_count;

    exp_t        q[$];
    logic [31:0] exp_pairs = '0;
    logic [31:0] last_w = '0;
    int          cyc = 0;
    int          ds_mode = 0;

    array_pair_unpacker #(.EMIT_SUM(ES), .CNT_W(CW)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .a_in         (a_in),
      .a_in_sync    (a_in_sync),
      .a_in_notify  (a_in_notify),
      .c_out        (c_out),
      .c_out_sync   (c_out_sync),
      .c_out_notify (c_out_notify),
      .pair_count   (pair_count)
    );

    function automatic string nm(input string s);
      return $sformatf("cfg%0d_%s", g, s);
    endfunction

    // One clock: advance past the edge, then drive downstream readiness
    task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      case (ds_mode)
        0:       c_out_sync = 1'b1;
        2:       c_out_sync = 1'b0;
        default: c_out_sync = ($urandom_range(0, 3) != 0);
      endcase
    endtask

    // Offer a pair until accepted; on acceptance queue the expected words
    task automatic issue(input logic [31:0] x0, input logic [31:0] x1, output int xcyc);
      int   n;
      bit   got;
      exp_t e;
      n = 0;
      got = 1'b0;
      a_in[0] = x0;
      a_in[1] = x1;
      a_in_sync = 1'b1;
      while (!got && n < 400) begin
        got = a_in_notify;
        tick();
        n++;
      end
      a_in_sync = 1'b0;
      xcyc = cyc;
      if (got) begin
        e.w = x0; e.last = 1'b0;             q.push_back(e);
        e.w = x1; e.last = (ES == 0);        q.push_back(e);
        if (ES != 0) begin
          e.w = sat_add(x0, x1); e.last = 1'b1; q.push_back(e);
        end
      end else begin
        check(nm("a_in_accept_timeout"), 0, 1);
      end
    endtask

    task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 400) begin
        tick();
        n++;
      end
      if (q.size() != 0) check(nm("drain_timeout"), q.size(), 0);
    endtask

    // Monitor: compare handshake state, output words and count against the model
    always @(negedge clk) begin
      if (!rst) begin
        check(nm("c_out_notify"), c_out_notify, (q.size() != 0));
        check(nm("a_in_notify"), a_in_notify, (q.size() == 0));
        if (q.size() == 0) begin
          check(nm("c_out_hold_idle"), c_out, last_w);
        end else if (c_out_notify) begin
          check(nm("c_out"), c_out, q[0].w);
          if (c_out_sync) begin
            if (q[0].last) begin
              check(nm("pair_count"), pair_count, exp_pairs[CW-1:0]);
              exp_pairs = exp_pairs + 1;
            end
            last_w = q[0].w;
            void'(q.pop_front());
          end
        end
      end
    end

    initial begin : drv
      int          t_prev;
      int          t_now;
      int          np;
      logic [31:0] dq[$];
      logic [31:0] npairs;
      t_prev = 0;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check(nm("rst_a_in_notify"), a_in_notify, 1);
      check(nm("rst_c_out_notify"), c_out_notify, 0);
      check(nm("rst_c_out"), c_out, 0);
      check(nm("rst_pair_count"), pair_count, 0);
      rst = 1'b0;

      // Directed back-to-back pairs with continuous downstream readiness
      if (g == 0) dq = '{32'd5, 32'd7, 32'h7FFF_FFF0, 32'h20,
                         32'h8000_0001, 32'hFFFF_FFFB, 32'hFFFF_FFFD, 32'd3};
      else        dq = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6,
                         32'd7, 32'd8, 32'd9, 32'd10};
      ds_mode = 0;
      tick();
      np = dq.size() / 2;
      for (int i = 0; i < np; i++) begin
        issue(dq[2*i], dq[2*i+1], t_now);
        if (i > 0) check(nm("cycles_per_pair"), t_now - t_prev, ES + 3);
        t_prev = t_now;
      end
      drain();
      npairs = 32'(np);
      check(nm("directed_pair_count"), pair_count, npairs[CW-1:0]);

      // Stall in WR1 for five cycles while upstream offers junk
      issue(32'h1234_5678, 32'hCAFE_F00D, t_now);
      ds_mode = 2;
      a_in[0] = 32'hDEAD_BEEF;
      a_in[1] = 32'h0BAD_0BAD;
      a_in_sync = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
        check(nm("stall_c_out"), c_out, 32'hCAFE_F00D);
        check(nm("stall_c_out_notify"), c_out_notify, 1);
        check(nm("stall_a_in_notify"), a_in_notify, 0);
        tick();
      end
      a_in_sync = 1'b0;
      ds_mode = 0;
      c_out_sync = 1'b1;
      drain();

      // Random data, random gaps, random back-pressure
      ds_mode = 1;
      for (int i = 0; i < 30; i++) begin
        repeat ($urandom_range(0, 2)) tick();
        issue(rv(), rv(), t_now);
      end
      drain();

      // Asynchronous reset while the first word is pending
      ds_mode = 2;
      issue(32'd11, 32'd22, t_now);
      #1 rst = 1'b1;
      #1;
      check(nm("arst_c_out_notify"), c_out_notify, 0);
      check(nm("arst_a_in_notify"), a_in_notify, 1);
      check(nm("arst_pair_count"), pair_count, 0);
      check(nm("arst_c_out"), c_out, 0);
      q.delete();
      exp_pairs = '0;
      last_w = '0;
      tick();
      tick();
      rst = 1'b0;
      ds_mode = 0;
      tick();
      issue(32'd33, 32'hFFFF_FFD4, t_now);
      drain();
      check(nm("post_rst_pair_count"), pair_count, 1);

      done[g] = 1'b1;
    end
  end

  initial begin
    wait (done[0] && done[1]);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/array_pair_unpacker.md
# array_pair_unpacker

Downstream consumer of the two-element array stream (`int_2`: two signed 32-bit elements) produced by the integer-to-array packing stage. It accepts one array per blocking handshake on `a_in` and serialises it onto a scalar integer stream `c_out`: element 0, then element 1, then optionally their saturated sum. It also counts completed arrays. All ports use the codebase's sync/notify blocking-port handshake.

## Interface
- `EMIT_SUM`, default 1: when 1, a third word (saturated `a[0]+a[1]`) follows each pair; when 0, only two words are emitted.
- `CNT_W`, default 16: width of `pair_count`.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-high
- `a_in`  in  2x32 (`int_2`)  incoming array; element 0 and element 1, each signed 32-bit
- `a_in_sync`  in  1  upstream has valid `a_in`
- `a_in_notify`  out  1  block is ready to read `a_in`
- `c_out`  out  32 signed  outgoing word
- `c_out_sync`  in  1  downstream is ready to take `c_out`
- `c_out_notify`  out  1  `c_out` is valid
- `pair_count`  out  `CNT_W`  number of arrays fully emitted, modulo 2^`CNT_W`

## Operation
- Handshake rules:
  - A transfer on a port occurs at a rising `clk` edge where that port's notify and sync are both 1.
  - Sync asserted while the matching notify is 0 is ignored.
  - A sync pulse is never remembered.
- FSM states: `READ`, `WR0`, `WR1`, `WRS`.
  - `READ`: `a_in_notify`=1, `c_out_notify`=0. On `a_in` transfer, latch both elements into internal `buf[0..1]`, then go to `WR0`.
  - `WR0`: `c_out`=`buf[0]`, `c_out_notify`=1, `a_in_notify`=0. On `c_out` transfer, go to `WR1`.
  - `WR1`: `c_out`=`buf[1]`. On transfer, go to `WRS` if `EMIT_SUM`=1; otherwise go to `READ` and increment `pair_count`.
  - `WRS`: `c_out`=sat(`buf[0]`+`buf[1]`). On transfer, go to `READ` and increment `pair_count`.
- Sum arithmetic:
  - Computed in 33-bit signed.
  - Result > 2147483647 clamps to 0x7FFFFFFF.
  - Result < -2147483648 clamps to 0x80000000.
  - Otherwise the low 32 bits are used.
- `pair_count` wraps from 2^`CNT_W`-1 to 0 without any flag.
- The block holds `c_out` stable for as long as `c_out_notify`=1 and no transfer has occurred.
- While not in a `WR*` state, `c_out` holds the last emitted value.
- Reset mid-operation: the latched pair is discarded, the FSM returns to `READ`, and no partial words are re-emitted.

## Timing
- All outputs are registered.
- Reset values: `a_in_notify`=1, `c_out_notify`=0, `c_out`=0, `pair_count`=0, state=`READ`, `buf`=`'{0,0}`.
- The `a_in` transfer at edge N gives `c_out`=`buf[0]` and `c_out_notify`=1, with `a_in_notify`=0, in the cycle after edge N.
- The final `c_out` transfer at edge M gives `a_in_notify`=1 and `c_out_notify`=0 after edge M. `pair_count` updates at the same edge.
- Minimum cycles per array with continuous syncs: 4 with `EMIT_SUM`=1, 3 with `EMIT_SUM`=0. There is no overlap between reading and writing.
- Downstream back-pressure: any number of cycles with `c_out_sync`=0 stalls in the current `WR*` state with outputs unchanged.
- Upstream idle: `READ` persists indefinitely with `a_in_notify`=1.
- `a_in_sync`=1 during `WR*` states is ignored. The upstream must hold its data until `a_in_notify` returns.

## Test plan
- Reset, then `a_in`=`'{5,7}` with `a_in_sync` pulsed in `READ` and `c_out_sync` held 1 -> `c_out` sequence 5, 7, 12 on consecutive cycles; `pair_count`=1; `a_in_notify` back to 1 four cycles after the read edge.
- Saturation: `'{0x7FFFFFF0, 0x20}` -> third word 0x7FFFFFFF. `'{0x80000001, -5}` -> third word 0x80000000. `'{-3, 3}` -> third word 0.
- Back-pressure: drop `c_out_sync` for 5 cycles while in `WR1` -> `c_out` stays `buf[1]` and `c_out_notify` stays 1 throughout; the sum is emitted only after `c_out_sync` returns. Raising `a_in_sync` during the stall is ignored.
- `EMIT_SUM`=0, three back-to-back pairs `'{1,2}`, `'{3,4}`, `'{5,6}` -> `c_out` 1,2,3,4,5,6; `pair_count`=3; 3 cycles per pair.
- Reset asserted asynchronously while in `WR0` -> `c_out_notify`=0 and `a_in_notify`=1 immediately; `pair_count`=0; the next pair is emitted cleanly with no stale word.
- `CNT_W`=2, five pairs -> `pair_count` reads 1,2,3,0,1.
